// File: rtl/udma_subsystem_pkg.sv
// Shared uDMA subsystem definitions: PWM register map and the pad-side PWM bundle.
package udma_subsystem_pkg;

  localparam int N_PWM_CH = 8;

  localparam logic [3:0] PWM_REG_CTRL   = 4'd0;
  localparam logic [3:0] PWM_REG_PERIOD = 4'd1;
  localparam logic [3:0] PWM_REG_POL    = 4'd2;
  localparam logic [3:0] PWM_REG_CMP0   = 4'd3;
  localparam logic [3:0] PWM_REG_STATUS = 4'd11;

  // pwm0_o sits in bit 0 of the packed bundle.
  typedef struct packed {
    logic pwm7_o;
    logic pwm6_o;
    logic pwm5_o;
    logic pwm4_o;
    logic pwm3_o;
    logic pwm2_o;
    logic pwm1_o;
    logic pwm0_o;
  } pwm_to_pad_t;

endpackage

// File: rtl/udma_pwm_ch.sv
// One PWM channel: active compare register (loaded from shadow on load_i) and registered output.
module udma_pwm_ch
  import udma_subsystem_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [CNT_WIDTH-1:0] cnt_i,
  input  logic                 en_i,
  input  logic                 load_i,
  input  logic [CNT_WIDTH-1:0] cmp_sh_i,
  input  logic                 pol_i,
  output logic                 out_o
);

  logic [CNT_WIDTH-1:0] cmp_act_q, cmp_act_d;
  logic                 out_q, out_d;

  // Next active compare value and next output level
  always_comb begin
    cmp_act_d = cmp_act_q;
    out_d     = pol_i;
    if (load_i) begin
      cmp_act_d = cmp_sh_i;
    end else begin
      cmp_act_d = cmp_act_q;
    end
    out_d = (en_i & (cnt_i < cmp_act_q)) ^ pol_i;
  end

  // Channel state flops
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmp_act_q <= '0;
      out_q     <= 1'b0;
    end else begin
      cmp_act_q <= cmp_act_d;
      out_q     <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/udma_pwm_gen.sv
// Eight-channel PWM timer with shared prescaler/period counter and double-buffered timing registers.
// Optional one-shot mode (CTRL bit1) is compiled in with `define UDMA_PWM_ONESHOT_EN.
module udma_pwm_gen
  import udma_subsystem_pkg::*;
#(
  parameter int CNT_WIDTH   = 16,
  parameter int PRESC_WIDTH = 8,
  parameter int N_CH        = N_PWM_CH
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_req_i,
  input  logic        cfg_we_i,
  input  logic [3:0]  cfg_addr_i,
  input  logic [31:0] cfg_wdata_i,
  output logic [31:0] cfg_rdata_o,
  output pwm_to_pad_t pwm_o,
  output logic        period_tick_o
);

`ifdef UDMA_PWM_ONESHOT_EN
  localparam logic ONESHOT_EN = 1'b1;
`else
  localparam logic ONESHOT_EN = 1'b0;
`endif

  localparam logic [CNT_WIDTH-1:0]   CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESC_WIDTH-1:0] PCNT_ONE = {{(PRESC_WIDTH-1){1'b0}}, 1'b1};

  logic                   en_q, en_d;
  logic                   oneshot_q, oneshot_d;
  logic [PRESC_WIDTH-1:0] presc_q, presc_d;
  logic [PRESC_WIDTH-1:0] pcnt_q, pcnt_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   period_sh_q, period_sh_d;
  logic [CNT_WIDTH-1:0]   period_act_q, period_act_d;
  logic [N_CH-1:0]        pol_q, pol_d;
  logic [CNT_WIDTH-1:0]   cmp_sh_q [N_CH];
  logic [CNT_WIDTH-1:0]   cmp_sh_d [N_CH];
  logic                   ptick_q, ptick_d;
  logic [31:0]            rdata_q, rdata_d;

  logic                   wr_s, rd_s, tick_s, wrap_s, load_s;
  logic [CNT_WIDTH-1:0]   cmp_rd_s;
  logic [N_CH-1:0]        ch_out_s;

  assign wr_s   = cfg_req_i & cfg_we_i;
  assign rd_s   = cfg_req_i & ~cfg_we_i;
  assign tick_s = en_q & (pcnt_q == presc_q);
  assign wrap_s = tick_s & (cnt_q == period_act_q);
  // While disabled the active set tracks the shadow, so enabling starts from fresh values.
  assign load_s = wrap_s | ~en_q;

  // Register writes, one-shot auto-disable and shadow-to-active period transfer
  always_comb begin
    en_d         = en_q;
    oneshot_d    = oneshot_q;
    presc_d      = presc_q;
    period_sh_d  = period_sh_q;
    period_act_d = period_act_q;
    pol_d        = pol_q;
    if (wrap_s && oneshot_q) begin
      en_d = 1'b0;
    end else begin
      en_d = en_q;
    end
    if (load_s) begin
      period_act_d = period_sh_q;
    end else begin
      period_act_d = period_act_q;
    end
    if (wr_s) begin
      case (cfg_addr_i)
        PWM_REG_CTRL: begin
          en_d      = cfg_wdata_i[0];
          oneshot_d = ONESHOT_EN & cfg_wdata_i[1];
          presc_d   = cfg_wdata_i[PRESC_WIDTH+7:8];
        end
        PWM_REG_PERIOD: period_sh_d = cfg_wdata_i[CNT_WIDTH-1:0];
        PWM_REG_POL:    pol_d       = cfg_wdata_i[N_CH-1:0];
        default:        pol_d       = pol_q;
      endcase
    end else begin
      pol_d = pol_q;
    end
    for (int i = 0; i < N_CH; i++) begin
      cmp_sh_d[i] = (wr_s && (cfg_addr_i == PWM_REG_CMP0 + 4'(i))) ?
                    cfg_wdata_i[CNT_WIDTH-1:0] : cmp_sh_q[i];
    end
  end

  // Prescaler and period counter
  always_comb begin
    pcnt_d = pcnt_q;
    cnt_d  = cnt_q;
    if (!en_q) begin
      pcnt_d = '0;
      cnt_d  = '0;
    end else if (tick_s) begin
      pcnt_d = '0;
      if (wrap_s) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      pcnt_d = pcnt_q + PCNT_ONE;
      cnt_d  = cnt_q;
    end
  end

  // Read-back mux (shadow values) and period tick
  always_comb begin
    cmp_rd_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      cmp_rd_s = cmp_rd_s | ((cfg_addr_i == PWM_REG_CMP0 + 4'(i)) ? cmp_sh_q[i] : '0);
    end
    ptick_d = wrap_s;
    rdata_d = 32'h0000_0000;
    if (rd_s) begin
      case (cfg_addr_i)
        PWM_REG_CTRL: begin
          rdata_d[0]               = en_q;
          rdata_d[1]               = oneshot_q;
          rdata_d[PRESC_WIDTH+7:8] = presc_q;
        end
        PWM_REG_PERIOD: rdata_d[CNT_WIDTH-1:0] = period_sh_q;
        PWM_REG_POL:    rdata_d[N_CH-1:0]      = pol_q;
        PWM_REG_STATUS: rdata_d[CNT_WIDTH-1:0] = cnt_q;
        default:        rdata_d[CNT_WIDTH-1:0] = cmp_rd_s;
      endcase
    end else begin
      rdata_d = 32'h0000_0000;
    end
  end

  // Control, counter and register-file flops
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q         <= 1'b0;
      oneshot_q    <= 1'b0;
      presc_q      <= '0;
      pcnt_q       <= '0;
      cnt_q        <= '0;
      period_sh_q  <= '0;
      period_act_q <= '0;
      pol_q        <= '0;
      ptick_q      <= 1'b0;
      rdata_q      <= 32'h0000_0000;
      for (int i = 0; i < N_CH; i++) begin
        cmp_sh_q[i] <= '0;
      end
    end else begin
      en_q         <= en_d;
      oneshot_q    <= oneshot_d;
      presc_q      <= presc_d;
      pcnt_q       <= pcnt_d;
      cnt_q        <= cnt_d;
      period_sh_q  <= period_sh_d;
      period_act_q <= period_act_d;
      pol_q        <= pol_d;
      ptick_q      <= ptick_d;
      rdata_q      <= rdata_d;
      for (int i = 0; i < N_CH; i++) begin
        cmp_sh_q[i] <= cmp_sh_d[i];
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    udma_pwm_ch #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_ch (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .cnt_i   (cnt_q),
      .en_i    (en_q),
      .load_i  (load_s),
      .cmp_sh_i(cmp_sh_q[g]),
      .pol_i   (pol_q[g]),
      .out_o   (ch_out_s[g])
    );
  end

  assign pwm_o         = pwm_to_pad_t'(ch_out_s);
  assign period_tick_o = ptick_q;
  assign cfg_rdata_o   = rdata_q;

endmodule

// File: tb/tb_udma_pwm_gen.sv
// Self-checking bench for udma_pwm_gen: directed scenarios plus randomized register traffic
// checked every cycle against an elapsed-time model of the PWM timer.
module tb_udma_pwm_gen;
  import udma_subsystem_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cfg_req_i, cfg_we_i;
  logic [3:0]  cfg_addr_i;
  logic [31:0] cfg_wdata_i, cfg_rdata_o;
  pwm_to_pad_t pwm_o;
  logic        period_tick_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  udma_pwm_gen dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cfg_req_i    (cfg_req_i),
    .cfg_we_i     (cfg_we_i),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_wdata_i  (cfg_wdata_i),
    .cfg_rdata_o  (cfg_rdata_o),
    .pwm_o        (pwm_o),
    .period_tick_o(period_tick_o)
  );

  // Model: m_e is the number of clocks already spent in the current period while enabled.
  logic       m_en, m_os;
  int         m_presc, m_period_sh, m_period_act, m_e;
  logic [7:0] m_pol;
  int         m_cmp_sh [8];
  int         m_cmp_act [8];

  logic [7:0] hp [256];
  logic       ht [256];
  int         hn;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 1'b0; m_os = 1'b0; m_presc = 0; m_period_sh = 0; m_period_act = 0; m_e = 0;
    m_pol = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m_cmp_sh[i] = 0;
      m_cmp_act[i] = 0;
    end
  endtask

  function automatic logic [31:0] reg_value(input logic [3:0] a, input int cnt);
    logic [31:0] v;
    v = 32'h0;
    case (a)
      4'd0: begin
        v[0] = m_en;
`ifdef UDMA_PWM_ONESHOT_EN
        v[1] = m_os;
`endif
        v[15:8] = m_presc[7:0];
      end
      4'd1:  v[15:0] = m_period_sh[15:0];
      4'd2:  v[7:0]  = m_pol;
      4'd11: v[15:0] = cnt[15:0];
      default: if (a >= 4'd3 && a <= 4'd10) v[15:0] = m_cmp_sh[a - 4'd3][15:0];
    endcase
    return v;
  endfunction

  // One clock: drive inputs, predict outputs from model, advance model, compare after the edge.
  task automatic cyc(input logic req, input logic we, input logic [3:0] addr, input logic [31:0] wd);
    int         cnt;
    logic       last, rd;
    logic [7:0] ep;
    logic [31:0] er;
    cfg_req_i = req; cfg_we_i = we; cfg_addr_i = addr; cfg_wdata_i = wd;
    cnt  = m_en ? m_e / (m_presc + 1) : 0;
    last = m_en && (m_e == (m_period_act + 1) * (m_presc + 1) - 1);
    for (int i = 0; i < 8; i++) ep[i] = (m_en && (cnt < m_cmp_act[i])) ^ m_pol[i];
    rd = req && !we;
    er = reg_value(addr, cnt);
    if (last || !m_en) begin
      m_period_act = m_period_sh;
      for (int i = 0; i < 8; i++) m_cmp_act[i] = m_cmp_sh[i];
    end
    m_e = (!m_en || last) ? 0 : m_e + 1;
`ifdef UDMA_PWM_ONESHOT_EN
    if (last && m_os) m_en = 1'b0;
`endif
    if (req && we) begin
      case (addr)
        4'd0: begin
          m_en = wd[0];
          m_presc = int'(wd[15:8]);
`ifdef UDMA_PWM_ONESHOT_EN
          m_os = wd[1];
`endif
        end
        4'd1: m_period_sh = int'(wd[15:0]);
        4'd2: m_pol = wd[7:0];
        default: if (addr >= 4'd3 && addr <= 4'd10) m_cmp_sh[addr - 4'd3] = int'(wd[15:0]);
      endcase
    end
    @(posedge clk_i);
    #1;
    check("pwm", {24'h0, pwm_o}, {24'h0, ep});
    check("period_tick", {31'h0, period_tick_o}, {31'h0, last});
    if (rd) check("rdata", cfg_rdata_o, er);
    if (hn < 256) begin
      hp[hn] = pwm_o;
      ht[hn] = period_tick_o;
    end
    hn++;
    cfg_req_i = 1'b0; cfg_we_i = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [3:0] a);
    cyc(1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 4'd0, 32'h0);
  endtask

  function automatic int count_hi(input int ch, input int a, input int b);
    int n;
    n = 0;
    for (int k = a; k <= b; k++) if (hp[k][ch]) n++;
    return n;
  endfunction

  function automatic int count_tick(input int a, input int b);
    int n;
    n = 0;
    for (int k = a; k <= b; k++) if (ht[k]) n++;
    return n;
  endfunction

  initial begin
    logic [31:0] wd;
    logic [3:0]  addr;
    rst_i = 1'b1; cfg_req_i = 1'b0; cfg_we_i = 1'b0; cfg_addr_i = 4'd0; cfg_wdata_i = 32'h0;
    hn = 0;
    model_reset();
    #12;
    check("reset_pwm", {24'h0, pwm_o}, 32'h0);
    check("reset_tick", {31'h0, period_tick_o}, 32'h0);
    check("reset_rdata", cfg_rdata_o, 32'h0);
    rst_i = 1'b0;

    // Period 10, duty 3/10, no prescale
    wr(PWM_REG_PERIOD, 32'd9); wr(PWM_REG_CMP0, 32'd3); wr(PWM_REG_CTRL, 32'h1);
    hn = 0; idle(30);
    check("t1_s0", {31'h0, hp[0][0]}, 32'd1);
    check("t1_s2", {31'h0, hp[2][0]}, 32'd1);
    check("t1_s3", {31'h0, hp[3][0]}, 32'd0);
    check("t1_s10", {31'h0, hp[10][0]}, 32'd1);
    check("t1_high", count_hi(0, 0, 29), 32'd9);
    check("t1_ticks", count_tick(0, 29), 32'd3);
    check("t1_tick9", {31'h0, ht[9]}, 32'd1);
    rd(PWM_REG_CTRL);
    check("t1_ctrl_rd", cfg_rdata_o, 32'h1);

    // Prescale 4, period 5 ticks -> 20 clocks, pwm1 high 8
    wr(PWM_REG_CTRL, 32'h0); wr(PWM_REG_PERIOD, 32'd4); wr(PWM_REG_CMP1_IDX(), 32'd2);
    wr(PWM_REG_CTRL, 32'h301);
    hn = 0; idle(40);
    check("t2_s7", {31'h0, hp[7][1]}, 32'd1);
    check("t2_s8", {31'h0, hp[8][1]}, 32'd0);
    check("t2_high", count_hi(1, 0, 39), 32'd16);
    check("t2_ticks", count_tick(0, 39), 32'd2);
    check("t2_tick19", {31'h0, ht[19]}, 32'd1);

    // Mid-period compare update takes effect at the next period
    wr(PWM_REG_CTRL, 32'h0); wr(PWM_REG_PERIOD, 32'd9); wr(PWM_REG_CMP0, 32'd3);
    wr(PWM_REG_CTRL, 32'h1);
    hn = 0; idle(5); wr(PWM_REG_CMP0, 32'd8); idle(24);
    check("t3_p1_high", count_hi(0, 0, 9), 32'd3);
    check("t3_p2_high", count_hi(0, 10, 19), 32'd8);
    check("t3_p3_high", count_hi(0, 20, 29), 32'd8);

    // cmp=0, cmp>period with inverted polarity, then disable
    wr(PWM_REG_CMP2_IDX(), 32'd0); wr(PWM_REG_CMP3_IDX(), 32'd12); wr(PWM_REG_POL, 32'h08);
    idle(12);
    hn = 0; idle(20);
    check("t4_ch2", count_hi(2, 0, 19), 32'd0);
    check("t4_ch3", count_hi(3, 0, 19), 32'd0);
    wr(PWM_REG_CTRL, 32'h0); idle(1);
    check("t4_idle", {24'h0, pwm_o}, 32'h08);
    rd(PWM_REG_POL);
    check("t4_pol_rd", cfg_rdata_o, 32'h08);

    // Asynchronous reset mid-period
    wr(PWM_REG_CTRL, 32'h1); idle(4);
    #2 rst_i = 1'b1;
    #1;
    check("t5_async_pwm", {24'h0, pwm_o}, 32'h0);
    check("t5_async_tick", {31'h0, period_tick_o}, 32'h0);
    #1 rst_i = 1'b0;
    model_reset();
    rd(PWM_REG_CMP0);
    check("t5_cmp0_rd", cfg_rdata_o, 32'h0);

`ifdef UDMA_PWM_ONESHOT_EN
    wr(PWM_REG_PERIOD, 32'd4); wr(PWM_REG_CMP0, 32'd2); wr(PWM_REG_CTRL, 32'h3);
    hn = 0; idle(12);
    check("t6_ticks", count_tick(0, 11), 32'd1);
    check("t6_high", count_hi(0, 0, 11), 32'd2);
    check("t6_idle", {24'h0, hp[11]}, 32'h0);
    rd(PWM_REG_CTRL);
    check("t6_ctrl_rd", cfg_rdata_o, 32'h2);
`endif

    // Randomized register traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        addr = 4'($urandom_range(0, 15));
        wd = $urandom;
        case (addr)
          4'd0: begin
            wd[0] = ($urandom_range(0, 3) != 0);
            wd[15:8] = m_en ? 8'(m_presc) : 8'($urandom_range(0, 3));
          end
          4'd1: wd[15:0] = 16'($urandom_range(0, 12));
          default: if (addr >= 4'd3 && addr <= 4'd10) wd[15:0] = 16'($urandom_range(0, 15));
        endcase
        cyc(1'b1, 1'($urandom_range(0, 1)), addr, wd);
      end else begin
        idle(1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic [3:0] PWM_REG_CMP1_IDX();
    return PWM_REG_CMP0 + 4'd1;
  endfunction

  function automatic logic [3:0] PWM_REG_CMP2_IDX();
    return PWM_REG_CMP0 + 4'd2;
  endfunction

  function automatic logic [3:0] PWM_REG_CMP3_IDX();
    return PWM_REG_CMP0 + 4'd3;
  endfunction

endmodule
